rob_commit_ctrl: RTL and testbench
==================================

# rob_commit_ctrl

Commit-stage controller that sits between the ROB's two oldest-entry read ports and the architectural state. Each cycle it decides which of the two tail entries retire and drives the ROB `commit_req`. It generates the ARF write ports and sequences the store-buffer commit handshake. On an exception or branch mispredict it raises a one-cycle pipeline flush and redirect.

## Interface
- DATA_W, 32, width of committed data and PC
- AREG_W, 5, architectural register index width
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- c_valid_i  in  2  tail entry i complete and valid (slot 0 = oldest)
- w_reg_i  in  2  entry i writes an architectural register
- w_mem_i  in  2  entry i is a store
- exc_i  in  2  entry i raised an exception
- bpu_fail_i  in  2  entry i is a mispredicted branch
- areg_i  in  2×AREG_W  destination register of entry i
- data_i  in  2×DATA_W  result of entry i
- pc_i  in  2×DATA_W  PC of entry i
- target_i  in  2×DATA_W  correct next PC for a mispredicted entry i
- sb_ready_i  in  1  store buffer accepts a commit this cycle
- commit_req_o  out  2  retire request to ROB; bit 1 is never set without bit 0
- arf_we_o  out  2  ARF write enables
- arf_waddr_o  out  2×AREG_W  ARF write addresses
- arf_wdata_o  out  2×DATA_W  ARF write data
- sb_commit_o  out  1  store-buffer commit valid
- flush_o  out  1  global flush, also feeds ROB flush_i
- redirect_o  out  1  fetch redirect valid
- redirect_pc_o  out  DATA_W  redirect target
- exc_o  out  1  exception taken
- exc_pc_o  out  DATA_W  faulting PC
- retired_cnt_o  out  32  total retired instructions (wraps)

## Operation
- FSM states: RUN, FLUSH.
- In RUN, slot 0 retires when all of these hold:
  - c_valid_i[0];
  - if w_mem_i[0], then sb_ready_i.
- Slot 1 retires when all of these hold:
  - slot 0 retires;
  - c_valid_i[1];
  - exc_i[0]=0 and bpu_fail_i[0]=0;
  - exc_i[1]=0 and bpu_fail_i[1]=0 (a faulting or mispredicted entry always retires alone, in slot 0);
  - not both w_mem (one store per cycle);
  - if w_mem_i[1], then sb_ready_i.
- arf_we_o[i] = retire_i & w_reg_i[i] & ~exc_i[i] & (areg_i[i]≠0).
- The address and data outputs pass areg_i/data_i through.
- If both slots write the same areg, both enables are asserted. The ARF gives slot 1 priority.
- sb_commit_o = OR of (retire_i & w_mem_i[i] & ~exc_i[i]).
- Exception on slot 0:
  - commit_req_o[0]=1, with no ARF or SB side effect;
  - latch pc_i[0] and go to FLUSH with exc pending.
- Mispredict on slot 0:
  - retires normally, including the ARF write;
  - latch target_i[0] and go to FLUSH with redirect pending.
- If exc_i[0] and bpu_fail_i[0] are both set, the exception wins.
- FLUSH (exactly one cycle):
  - flush_o=1;
  - exc_o/exc_pc_o or redirect_o/redirect_pc_o from the latches;
  - commit_req_o, arf_we_o and sb_commit_o forced to 0;
  - return to RUN.
- retired_cnt_o increments by popcount(commit_req_o) each cycle, wrapping modulo 2^32. An excepting entry is counted.

## Timing
- commit_req_o, arf_*, and sb_commit_o are combinational from the inputs in RUN, so zero-latency commit against the ROB tail registers.
- flush_o, redirect_o, and exc_o are registered: high exactly one cycle after the triggering retire, and low otherwise.
- A back-to-back trigger is impossible, because the ROB is empty after the flush.
- Reset behaviour:
  - state resets to RUN;
  - all outputs reset to 0, including retired_cnt_o and the latched PCs;
  - the first retire is possible in the cycle after rst_n rises.
- Reset asserted in FLUSH aborts the flush; no flush_o is seen after reset.
- When sb_ready_i is low with a store at slot 0, the controller stalls with commit_req_o=0. It holds no state and re-evaluates every cycle.

## Structure
- Shared package:
  - commit_slot_t struct (c_valid, w_reg, w_mem, exc, bpu_fail, areg, data, pc, target);
  - commit_state_e {RUN, FLUSH}.
- Ports may be packed as commit_slot_t [1:0].
- Single module. An optional leaf `commit_slot_sel` computes the retire vector combinationally.

## Test plan
- Both slots valid, w_reg, areg 3/4, no store → commit_req=2'b11, arf_we=2'b11, retired_cnt +2.
- Slot 0 store with sb_ready=0 for 3 cycles, then 1 → commit_req=0 for 3 cycles, then 2'b01 (or 2'b11) with sb_commit=1 for one cycle.
- Both slots stores with sb_ready=1 → cycle 1 commit_req=2'b01, cycle 2 (ROB shifted) another single retire.
- Slot 0 exc_i=1, pc=0x1c000100 → commit_req=2'b01, arf_we=0; next cycle flush_o=1, exc_o=1, exc_pc_o=0x1c000100, commit_req=0; following cycle all low.
- Slot 1 bpu_fail with target 0x1c000200, slot 0 normal → cycle 1 commit_req=2'b01. Next cycle slot 1 is now slot 0 and retires with its ARF write. Cycle after: flush_o=1, redirect_pc_o=0x1c000200.
- Slot 0 w_reg to areg 0 → arf_we[0]=0 while commit_req[0]=1. Also: rst_n low during FLUSH → flush_o=0 on the next cycle.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// Shared types for the ROB commit stage: per-slot entry view, the reduced
// control view used by the retire selector, and the controller state encoding.
package rob_commit_pkg;

   localparam int DATA_W_P = 32;
   localparam int AREG_W_P = 5;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } commit_state_e;

   typedef struct packed {
      logic                c_valid;
      logic                w_reg;
      logic                w_mem;
      logic                exc;
      logic                bpu_fail;
      logic [AREG_W_P-1:0] areg;
      logic [DATA_W_P-1:0] data;
      logic [DATA_W_P-1:0] pc;
      logic [DATA_W_P-1:0] target;
   } commit_slot_t;

   // Only the bits the retire decision needs; areg reduced to "not x0".
   typedef struct packed {
      logic c_valid;
      logic w_reg;
      logic w_mem;
      logic exc;
      logic bpu_fail;
      logic areg_nz;
   } commit_ctl_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/rob_commit_ctrl_sel.sv
// Combinational retire selector: decides which of the two oldest ROB entries
// retire this cycle and derives the ARF write enables and store commit.
module commit_slot_sel
   import rob_commit_pkg::*;
(
   input  logic              i_run,
   input  commit_ctl_t [1:0] i_ctl,
   input  logic              i_sb_ready,
   output logic [1:0]        o_retire,
   output logic [1:0]        o_arf_we,
   output logic              o_sb_commit
);

   logic       w_ret0;
   logic       w_ret1;
   logic       w_fault0;
   logic       w_fault1;
   logic       w_two_stores;
   logic [1:0] w_sb_slot;

   assign w_fault0     = i_ctl[0].exc | i_ctl[0].bpu_fail;
   assign w_fault1     = i_ctl[1].exc | i_ctl[1].bpu_fail;
   assign w_two_stores = i_ctl[0].w_mem & i_ctl[1].w_mem;

   assign w_ret0 = i_run & i_ctl[0].c_valid & (~i_ctl[0].w_mem | i_sb_ready);

   // Faulting or mispredicted entries retire alone so the flush lines up with them.
   assign w_ret1 = w_ret0 & i_ctl[1].c_valid & ~w_fault0 & ~w_fault1
                 & ~w_two_stores & (~i_ctl[1].w_mem | i_sb_ready);

   assign o_retire = {w_ret1, w_ret0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_side
         assign o_arf_we[gi]  = o_retire[gi] & i_ctl[gi].w_reg & ~i_ctl[gi].exc & i_ctl[gi].areg_nz;
         assign w_sb_slot[gi] = o_retire[gi] & i_ctl[gi].w_mem & ~i_ctl[gi].exc;
      end
   endgenerate

   assign o_sb_commit = |w_sb_slot;

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit-stage controller: zero-latency retire of up to two tail entries,
// ARF/store-buffer side effects, and a one-cycle flush on exception/mispredict.
module rob_commit_ctrl
   import rob_commit_pkg::*;
#(
   parameter int DATA_W = DATA_W_P,
   parameter int AREG_W = AREG_W_P
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          c_valid_i,
   input  logic [1:0]          w_reg_i,
   input  logic [1:0]          w_mem_i,
   input  logic [1:0]          exc_i,
   input  logic [1:0]          bpu_fail_i,
   input  logic [2*AREG_W-1:0] areg_i,
   input  logic [2*DATA_W-1:0] data_i,
   input  logic [2*DATA_W-1:0] pc_i,
   input  logic [2*DATA_W-1:0] target_i,
   input  logic                sb_ready_i,
   output logic [1:0]          commit_req_o,
   output logic [1:0]          arf_we_o,
   output logic [2*AREG_W-1:0] arf_waddr_o,
   output logic [2*DATA_W-1:0] arf_wdata_o,
   output logic                sb_commit_o,
   output logic                flush_o,
   output logic                redirect_o,
   output logic [DATA_W-1:0]   redirect_pc_o,
   output logic                exc_o,
   output logic [DATA_W-1:0]   exc_pc_o,
   output logic [31:0]         retired_cnt_o
);

   commit_slot_t [1:0] w_slot;
   commit_ctl_t  [1:0] w_ctl;
   logic [1:0]         w_retire;
   logic               w_run;
   logic               w_unused;

   commit_state_e      r_state;
   commit_state_e      w_state_next;
   logic               r_exc_pend;
   logic               w_exc_pend_next;
   logic               r_redir_pend;
   logic               w_redir_pend_next;
   logic [DATA_W-1:0]  r_exc_pc;
   logic [DATA_W-1:0]  w_exc_pc_next;
   logic [DATA_W-1:0]  r_redir_pc;
   logic [DATA_W-1:0]  w_redir_pc_next;
   logic [31:0]        r_retired_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         assign w_slot[gi] = '{
            c_valid:  c_valid_i[gi],
            w_reg:    w_reg_i[gi],
            w_mem:    w_mem_i[gi],
            exc:      exc_i[gi],
            bpu_fail: bpu_fail_i[gi],
            areg:     areg_i[gi*AREG_W +: AREG_W],
            data:     data_i[gi*DATA_W +: DATA_W],
            pc:       pc_i[gi*DATA_W +: DATA_W],
            target:   target_i[gi*DATA_W +: DATA_W]
         };
         assign w_ctl[gi] = '{
            c_valid:  w_slot[gi].c_valid,
            w_reg:    w_slot[gi].w_reg,
            w_mem:    w_slot[gi].w_mem,
            exc:      w_slot[gi].exc,
            bpu_fail: w_slot[gi].bpu_fail,
            areg_nz:  |w_slot[gi].areg
         };
         assign arf_waddr_o[gi*AREG_W +: AREG_W] = w_slot[gi].areg;
         assign arf_wdata_o[gi*DATA_W +: DATA_W] = w_slot[gi].data;
      end
   endgenerate

   // Slot 1 never triggers a flush itself; it is re-presented in slot 0 first.
   assign w_unused = ^{w_slot[1].pc, w_slot[1].target};

   assign w_run = (r_state == RUN);

   commit_slot_sel u_sel (
      .i_run       (w_run),
      .i_ctl       (w_ctl),
      .i_sb_ready  (sb_ready_i),
      .o_retire    (w_retire),
      .o_arf_we    (arf_we_o),
      .o_sb_commit (sb_commit_o)
   );

   assign commit_req_o  = w_retire;
   assign exc_pc_o      = r_exc_pc;
   assign redirect_pc_o = r_redir_pc;
   assign retired_cnt_o = r_retired_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_exc_pend    <= 1'b0;
         r_redir_pend  <= 1'b0;
         r_exc_pc      <= '0;
         r_redir_pc    <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state       <= w_state_next;
         r_exc_pend    <= w_exc_pend_next;
         r_redir_pend  <= w_redir_pend_next;
         r_exc_pc      <= w_exc_pc_next;
         r_redir_pc    <= w_redir_pc_next;
         r_retired_cnt <= r_retired_cnt + {30'd0, popcount2(w_retire)};
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_exc_pend_next   = r_exc_pend;
      w_redir_pend_next = r_redir_pend;
      w_exc_pc_next     = r_exc_pc;
      w_redir_pc_next   = r_redir_pc;
      flush_o           = 1'b0;
      exc_o             = 1'b0;
      redirect_o        = 1'b0;
      case (r_state)
         RUN: begin
            if (w_retire[0] && (w_slot[0].exc || w_slot[0].bpu_fail)) begin
               w_state_next = FLUSH;
               // An exception on a mispredicted entry takes precedence.
               if (w_slot[0].exc) begin
                  w_exc_pend_next = 1'b1;
                  w_exc_pc_next   = w_slot[0].pc;
               end else begin
                  w_redir_pend_next = 1'b1;
                  w_redir_pc_next   = w_slot[0].target;
               end
            end
         end
         FLUSH: begin
            flush_o           = 1'b1;
            exc_o             = r_exc_pend;
            redirect_o        = r_redir_pend;
            w_state_next      = RUN;
            w_exc_pend_next   = 1'b0;
            w_redir_pend_next = 1'b0;
         end
         default: begin
            w_state_next = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: vector table plus hand-written
// flush/reset sequences, each cycle's expectation queued then compared.
module tb_rob_commit_ctrl;
   import rob_commit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  c_valid_i, w_reg_i, w_mem_i, exc_i, bpu_fail_i;
   logic [9:0]  areg_i;
   logic [63:0] data_i, pc_i, target_i;
   logic        sb_ready_i;
   logic [1:0]  commit_req_o, arf_we_o;
   logic [9:0]  arf_waddr_o;
   logic [63:0] arf_wdata_o;
   logic        sb_commit_o, flush_o, redirect_o, exc_o;
   logic [31:0] redirect_pc_o, exc_pc_o, retired_cnt_o;

   always #5 clk = ~clk;

   rob_commit_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .c_valid_i     (c_valid_i),
      .w_reg_i       (w_reg_i),
      .w_mem_i       (w_mem_i),
      .exc_i         (exc_i),
      .bpu_fail_i    (bpu_fail_i),
      .areg_i        (areg_i),
      .data_i        (data_i),
      .pc_i          (pc_i),
      .target_i      (target_i),
      .sb_ready_i    (sb_ready_i),
      .commit_req_o  (commit_req_o),
      .arf_we_o      (arf_we_o),
      .arf_waddr_o   (arf_waddr_o),
      .arf_wdata_o   (arf_wdata_o),
      .sb_commit_o   (sb_commit_o),
      .flush_o       (flush_o),
      .redirect_o    (redirect_o),
      .redirect_pc_o (redirect_pc_o),
      .exc_o         (exc_o),
      .exc_pc_o      (exc_pc_o),
      .retired_cnt_o (retired_cnt_o)
   );

   typedef struct {
      string       name;
      logic        rstn;
      logic [1:0]  cv, wr, wm, ex, bp;
      logic [4:0]  a0, a1;
      logic        sbr;
      logic [31:0] pc0, tg0;
      logic [1:0]  req, we;
      logic        sb, fl, xo, rd;
      logic [31:0] opc;
      logic [63:0] dat;
   } vec_t;

   vec_t        sb_q[$];
   vec_t        tbl[13];
   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] exp_cnt = 32'd0;

   function automatic vec_t mk(input string name, input logic rstn,
                               input logic [1:0] cv, wr, wm, ex, bp,
                               input logic [4:0] a0, a1, input logic sbr,
                               input logic [31:0] pc0, tg0,
                               input logic [1:0] req, we,
                               input logic sb, fl, xo, rd, input logic [31:0] opc);
      vec_t v;
      v.name = name; v.rstn = rstn;
      v.cv = cv; v.wr = wr; v.wm = wm; v.ex = ex; v.bp = bp;
      v.a0 = a0; v.a1 = a1; v.sbr = sbr; v.pc0 = pc0; v.tg0 = tg0;
      v.req = req; v.we = we; v.sb = sb; v.fl = fl; v.xo = xo; v.rd = rd;
      v.opc = opc; v.dat = 64'd0;
      return v;
   endfunction

   task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   task automatic check_front();
      vec_t e;
      e = sb_q.pop_front();
      $display("txn %-10s req=%b we=%b sb=%b fl=%b exc=%b rd=%b cnt=%0d",
               e.name, commit_req_o, arf_we_o, sb_commit_o, flush_o, exc_o, redirect_o, retired_cnt_o);
      chk({e.name, ".req"},   64'(commit_req_o),  64'(e.req));
      chk({e.name, ".we"},    64'(arf_we_o),      64'(e.we));
      chk({e.name, ".sb"},    64'(sb_commit_o),   64'(e.sb));
      chk({e.name, ".flush"}, 64'(flush_o),       64'(e.fl));
      chk({e.name, ".exc"},   64'(exc_o),         64'(e.xo));
      chk({e.name, ".redir"}, 64'(redirect_o),    64'(e.rd));
      chk({e.name, ".waddr"}, 64'(arf_waddr_o),   64'({e.a1, e.a0}));
      chk({e.name, ".wdata"}, arf_wdata_o,        e.dat);
      chk({e.name, ".cnt"},   64'(retired_cnt_o), 64'(exp_cnt));
      if (e.xo) chk({e.name, ".exc_pc"}, 64'(exc_pc_o), 64'(e.opc));
      if (e.rd) chk({e.name, ".redir_pc"}, 64'(redirect_pc_o), 64'(e.opc));
      if (!e.rstn) exp_cnt = 32'd0;
      else         exp_cnt = exp_cnt + 32'(e.req[0]) + 32'(e.req[1]);
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk);
      #1;
      v.dat      = {$urandom, $urandom};
      rst_n      = v.rstn;
      c_valid_i  = v.cv;
      w_reg_i    = v.wr;
      w_mem_i    = v.wm;
      exc_i      = v.ex;
      bpu_fail_i = v.bp;
      areg_i     = {v.a1, v.a0};
      data_i     = v.dat;
      pc_i       = {32'h0BAD_0000, v.pc0};
      target_i   = {32'h0BAD_1111, v.tg0};
      sb_ready_i = v.sbr;
      sb_q.push_back(v);
      @(negedge clk);
      check_front();
   endtask

   initial begin
      rst_n = 1'b0;
      c_valid_i = '0; w_reg_i = '0; w_mem_i = '0; exc_i = '0; bpu_fail_i = '0;
      areg_i = '0; data_i = '0; pc_i = '0; target_i = '0; sb_ready_i = 1'b0;

      //          name         rst cv     wr     wm     ex     bp     a0 a1 sbr pc0 tg0 req    we     sb fl xo rd opc
      tbl[0]  = mk("dual_alu",  1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 3, 4, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0);
      tbl[1]  = mk("st_stall1", 1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      tbl[2]  = mk("st_stall2", 1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      tbl[3]  = mk("st_stall3", 1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      tbl[4]  = mk("st_go",     1, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 1, 2, 1, 0, 0, 2'b11, 2'b10, 1, 0, 0, 0, 0);
      tbl[5]  = mk("two_st_a",  1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 1, 2, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
      tbl[6]  = mk("two_st_b",  1, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2, 0, 1, 0, 0, 2'b01, 2'b00, 1, 0, 0, 0, 0);
      tbl[7]  = mk("areg0",     1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 5, 0, 0, 0, 2'b11, 2'b10, 0, 0, 0, 0, 0);
      tbl[8]  = mk("s0_empty",  1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 3, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      tbl[9]  = mk("s1_st_blk", 1, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 6, 1, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0);
      tbl[10] = mk("same_areg", 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 7, 7, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0);
      tbl[11] = mk("single",    1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 9, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0);
      tbl[12] = mk("s1_st_ok",  1, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 6, 1, 1, 0, 0, 2'b11, 2'b01, 1, 0, 0, 0, 0);

      run_vec(mk("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      run_vec(mk("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("rst.exc_pc",   64'(exc_pc_o),      64'd0);
      chk("rst.redir_pc", 64'(redirect_pc_o), 64'd0);

      for (int i = 0; i < 13; i++) run_vec(tbl[i]);

      // exception on a store in slot 0: retires with no side effect, then one flush cycle
      run_vec(mk("exc",       1, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 6, 7, 1, 32'h1c000100, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("exc_fl",    1, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1, 2, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 32'h1c000100));
      run_vec(mk("exc_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

      // mispredict in slot 1 retires alone after shifting into slot 0
      run_vec(mk("bp1_a",     1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 1, 8, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0));
      run_vec(mk("bp1_b",     1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8, 0, 0, 0, 32'h1c000200, 2'b01, 2'b01, 0, 0, 0, 0, 0));
      run_vec(mk("bp_fl",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 32'h1c000200));
      run_vec(mk("bp_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

      // exception and mispredict together: exception wins
      run_vec(mk("exc_bp",    1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 4, 0, 0, 32'h1c000180, 32'h1c000999, 2'b01, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("exc_bp_fl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 32'h1c000180));

      // reset during the flush cycle, then reset on the triggering cycle
      run_vec(mk("rst_trig",  1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 32'h1c000300, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("rst_in_fl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 32'h1c000300));
      run_vec(mk("rst_post",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      chk("rst_post.exc_pc",   64'(exc_pc_o),      64'd0);
      chk("rst_post.redir_pc", 64'(redirect_pc_o), 64'd0);
      run_vec(mk("rst_trig2", 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 32'h1c000400, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0));
      run_vec(mk("rst_post2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      chk("rst_post2.exc_pc", 64'(exc_pc_o), 64'd0);
      run_vec(mk("first_ret", 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 3, 4, 0, 0, 0, 2'b11, 2'b11, 0, 0, 0, 0, 0));
      run_vec(mk("idle_end",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
